regfile_port_arbiter: RTL and testbench

Round-robin controller that shares the 16 x 32-bit register file's single write port and single read port between two requesters. Each cycle it grants at most one request, drives the register file's load enable, write address/data (toward the write decoder) and read select (toward the 16:1 read mux) one cycle later, and returns a completion response to the granted requester. Sits between the two register-file clients and the register file datapath.

---
 rtl/regfile_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter
//
// Shares the single write port and single read port of a 16 x 32-bit register
// file between two requesters using round-robin arbitration. At most one
// request is accepted per cycle. The block then moves it through a two-stage
// pipeline:
//   stage 1 (issue)    : drives rf_ld / rf_waddr / rf_wdata / rf_raddr
//   stage 2 (response) : returns a one-cycle completion pulse to the requester
// A write to a register whose WP_MASK bit is set is dropped (no rf_ld). It still
// completes, with rsp_err = 1.
//
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   rN_valid/we/addr/wdata    : request from requester N (N = 0, 1)
//   rN_ready                  : combinational grant; transfer on valid && ready
//   rN_rsp_valid/err/data     : completion response, two cycles after accept
//   rf_ld, rf_waddr, rf_wdata : register file write port (decoder side)
//   rf_raddr, rf_rdata        : register file read mux select / read data
// -----------------------------------------------------------------------------
module regfile_port_arbiter #(
  parameter logic [15:0] WP_MASK = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        r0_valid,
  input  logic        r0_we,
  input  logic [3:0]  r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ready,
  output logic        r0_rsp_valid,
  output logic        r0_rsp_err,
  output logic [31:0] r0_rsp_data,

  input  logic        r1_valid,
  input  logic        r1_we,
  input  logic [3:0]  r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ready,
  output logic        r1_rsp_valid,
  output logic        r1_rsp_err,
  output logic [31:0] r1_rsp_data,

  output logic        rf_ld,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [3:0]  rf_raddr,
  input  logic [31:0] rf_rdata
);

  typedef struct packed {
    logic        id;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        err;
  } issue_t;

  // Id of the requester granted most recently. Reset to 1 so that requester 0
  // wins the first contention.
  logic        r_last;

  logic        r_s1_valid;
  issue_t      r_s1;

  logic        r_s2_valid;
  logic        r_s2_id;
  logic        r_s2_err;
  logic [31:0] r_s2_data;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_accept;
  issue_t      w_req;

  // Grant logic. When both requesters are valid, the one that was not granted
  // last time wins. Gating with rst_n keeps ready low throughout reset.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    w_req    = '0;
    w_gnt0   = rst_n && r0_valid && (!r1_valid || r_last);
    w_gnt1   = rst_n && r1_valid && (!r0_valid || !r_last);
    w_accept = w_gnt0 || w_gnt1;

    if (w_gnt1) begin
      w_req.id    = 1'b1;
      w_req.we    = r1_we;
      w_req.addr  = r1_addr;
      w_req.wdata = r1_wdata;
    end else begin
      w_req.id    = 1'b0;
      w_req.we    = r0_we;
      w_req.addr  = r0_addr;
      w_req.wdata = r0_wdata;
    end
    // Only writes can be protected. Reads of a masked register are legal.
    w_req.err = w_req.we && WP_MASK[w_req.addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, including the datapath fields, is cleared on reset.
    // This discards in-flight work and keeps rf_* at 0 while reset is active.
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= 1'b0;
      r_s2_err   <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every stage
      // reads the values its neighbours had before this edge.
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_last <= w_gnt1;
        r_s1   <= w_req;
      end

      // The read mux output is sampled at the end of the stage-1 cycle. A write
      // issued one cycle earlier has committed by then, so read-after-write
      // returns the new value.
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_id   <= r_s1.id;
        r_s2_err  <= r_s1.err;
        r_s2_data <= r_s1.we ? 32'h0 : rf_rdata;
      end
    end
  end

  assign r0_ready = w_gnt0;
  assign r1_ready = w_gnt1;

  // All register-file controls come directly from stage-1 flops.
  assign rf_ld    = r_s1_valid && r_s1.we && !r_s1.err;
  assign rf_waddr = r_s1.addr;
  assign rf_wdata = r_s1.wdata;
  assign rf_raddr = r_s1.addr;

  assign r0_rsp_valid = r_s2_valid && !r_s2_id;
  assign r0_rsp_err   = r0_rsp_valid && r_s2_err;
  assign r0_rsp_data  = r0_rsp_valid ? r_s2_data : 32'h0;

  assign r1_rsp_valid = r_s2_valid && r_s2_id;
  assign r1_rsp_err   = r1_rsp_valid && r_s2_err;
  assign r1_rsp_data  = r1_rsp_valid ? r_s2_data : 32'h0;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_port_arbiter
//
// Drives inputs at each falling edge and samples outputs 1 ns later.
// The reference model works at transaction level. It keeps its own round-robin
// pointer and its own view of the register contents. On acceptance it schedules
// the expected response for two cycles later. For an unprotected write it also
// schedules the register-file write for one cycle later.
// The bench also holds a plain 16 x 32 register file as the environment the
// DUT drives.
// -----------------------------------------------------------------------------
module tb_regfile_port_arbiter;

  localparam logic [15:0] WP = 16'h0001;

  logic        clk;
  logic        rst_n;
  logic        r0_valid, r0_we, r0_ready, r0_rsp_valid, r0_rsp_err;
  logic [3:0]  r0_addr;
  logic [31:0] r0_wdata, r0_rsp_data;
  logic        r1_valid, r1_we, r1_ready, r1_rsp_valid, r1_rsp_err;
  logic [3:0]  r1_addr;
  logic [31:0] r1_wdata, r1_rsp_data;
  logic        rf_ld;
  logic [3:0]  rf_waddr, rf_raddr;
  logic [31:0] rf_wdata, rf_rdata;

  regfile_port_arbiter #(.WP_MASK(WP)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_err(r0_rsp_err),
    .r0_rsp_data(r0_rsp_data),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_err(r1_rsp_err),
    .r1_rsp_data(r1_rsp_data),
    .rf_ld(rf_ld), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment register file: combinational read, write on the rising edge.
  logic [31:0] rf_mem [16];
  assign rf_rdata = rf_mem[rf_raddr];
  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 32'hC0DE_0000 + 32'(i);
    forever begin
      @(posedge clk);
      if (rf_ld) rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  // ---------------- reference model ----------------
  typedef struct { int cyc; bit id; bit err; logic [31:0] data; } rsp_t;
  typedef struct { int cyc; logic [3:0] addr; logic [31:0] data; } wr_t;

  rsp_t        rsp_q[$];
  wr_t         wr_q[$];
  logic [31:0] m_mem [16];
  bit          m_last;
  int          cyc;
  int          checks;
  int          failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs, advance the model.
  task automatic step(input logic v0, input logic we0, input logic [3:0] a0,
                      input logic [31:0] d0, input logic v1, input logic we1,
                      input logic [3:0] a1, input logic [31:0] d1,
                      input bit use_tbl, input logic tg0, input logic tg1,
                      output bit g0, output bit g1);
    rsp_t        r;
    wr_t         w;
    logic        ev0, ee0, ev1, ee1, we, err;
    logic [31:0] ed0, ed1, dd, rd;
    logic [3:0]  aa;
    @(negedge clk);
    r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    #1;
    // expected register file write this cycle; it commits at the coming edge
    if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
      w = wr_q.pop_front();
      check("rf_write", 64'({rf_ld, rf_waddr, rf_wdata}), 64'({1'b1, w.addr, w.data}));
      m_mem[w.addr] = w.data;
    end else begin
      check("rf_ld_idle", 64'(rf_ld), 64'(0));
    end
    // expected responses this cycle
    ev0 = 0; ee0 = 0; ed0 = 0; ev1 = 0; ee1 = 0; ed1 = 0;
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
      r = rsp_q.pop_front();
      if (r.id) begin ev1 = 1; ee1 = r.err; ed1 = r.data; end
      else      begin ev0 = 1; ee0 = r.err; ed0 = r.data; end
    end
    check("rsp0", 64'({r0_rsp_valid, r0_rsp_err, r0_rsp_data}), 64'({ev0, ee0, ed0}));
    check("rsp1", 64'({r1_rsp_valid, r1_rsp_err, r1_rsp_data}), 64'({ev1, ee1, ed1}));
    // round-robin rule
    g0 = 0; g1 = 0;
    if (v0 && v1) begin
      if (m_last) g0 = 1; else g1 = 1;
    end else if (v0) g0 = 1;
    else if (v1) g1 = 1;
    if (use_tbl) check("grant_tbl", 64'({r0_ready, r1_ready}), 64'({tg0, tg1}));
    else         check("grant", 64'({r0_ready, r1_ready}), 64'({g0, g1}));
    if (g0 || g1) begin
      we  = g1 ? we1 : we0;
      aa  = g1 ? a1 : a0;
      dd  = g1 ? d1 : d0;
      err = we && WP[aa];
      rd  = we ? 32'h0 : m_mem[aa];
      rsp_q.push_back('{cyc + 2, g1, err, rd});
      if (we && !err) wr_q.push_back('{cyc + 1, aa, dd});
      m_last = g1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit g0, g1;
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 1, 0, 0, g0, g1);
  endtask

  // Assert reset just after a rising edge and hold it for n cycles, checking
  // that every output is quiet even with both requesters valid.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 0; r0_valid = 1; r1_valid = 1;
      @(negedge clk);
      #1;
      check("rst_ready", 64'({r0_ready, r1_ready}), 64'(0));
      check("rst_rsp", 64'({r0_rsp_valid, r0_rsp_err, r0_rsp_data, r1_rsp_valid, r1_rsp_err}), 64'(0));
      check("rst_rsp1_data", 64'(r1_rsp_data), 64'(0));
      check("rst_rf", 64'({rf_ld, rf_waddr, rf_raddr, rf_wdata}), 64'(0));
      cyc++;
    end
    r0_valid = 0; r1_valid = 0;
    rst_n = 1;
    rsp_q.delete();
    wr_q.delete();
    m_last = 1;
  endtask

  typedef struct {
    logic v0; logic we0; logic [3:0] a0; logic [31:0] d0;
    logic v1; logic we1; logic [3:0] a1; logic [31:0] d1;
    logic g0; logic g1;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic we0, input logic [3:0] a0,
                              input logic [31:0] d0, input logic v1, input logic we1,
                              input logic [3:0] a1, input logic [31:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          g0, g1;
    logic        p0v, p0we, p1v, p1we;
    logic [3:0]  p0a, p1a;
    logic [31:0] p0d, p1d;

    checks = 0; failures = 0; cyc = 0; m_last = 1;
    for (int i = 0; i < 16; i++) m_mem[i] = 32'hC0DE_0000 + 32'(i);
    rst_n = 0;
    r0_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;

    // Stimulus table. A requester that loses arbitration holds its request.
    // Continuous contention: grants alternate, starting with r0.
    tbl.push_back(mk(1, 1, 4'd5, 32'h100, 1, 0, 4'd5, 32'h0,   1, 0));
    tbl.push_back(mk(1, 1, 4'd5, 32'h101, 1, 0, 4'd5, 32'h0,   0, 1));
    tbl.push_back(mk(1, 1, 4'd5, 32'h101, 1, 0, 4'd6, 32'h0,   1, 0));
    tbl.push_back(mk(1, 1, 4'd6, 32'h102, 1, 0, 4'd6, 32'h0,   0, 1));
    tbl.push_back(mk(1, 1, 4'd6, 32'h102, 1, 0, 4'd5, 32'h0,   1, 0));
    tbl.push_back(mk(1, 0, 4'd5, 32'h0,   1, 0, 4'd5, 32'h0,   0, 1));
    tbl.push_back(mk(1, 0, 4'd5, 32'h0,   1, 1, 4'd7, 32'h200, 1, 0));
    tbl.push_back(mk(1, 1, 4'd7, 32'h300, 1, 1, 4'd7, 32'h200, 0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   0, 0, 4'd0, 32'h0,   0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   0, 0, 4'd0, 32'h0,   0, 0));
    // Write 3 then read 3 back-to-back (read-after-write).
    tbl.push_back(mk(1, 1, 4'd3, 32'hDEADBEEF, 0, 0, 4'd0, 32'h0, 1, 0));
    tbl.push_back(mk(1, 0, 4'd3, 32'h0,   0, 0, 4'd0, 32'h0,   1, 0));
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   0, 0, 4'd0, 32'h0,   0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   0, 0, 4'd0, 32'h0,   0, 0));
    // Protected write to register 0, then read it back.
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   1, 1, 4'd0, 32'h1234, 0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   1, 0, 4'd0, 32'h0,   0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   0, 0, 4'd0, 32'h0,   0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   0, 0, 4'd0, 32'h0,   0, 0));
    // r1 alone for three cycles, then contention: r0 must win.
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   1, 0, 4'd1, 32'h0,   0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   1, 0, 4'd2, 32'h0,   0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   1, 1, 4'd2, 32'h55,  0, 1));
    tbl.push_back(mk(1, 0, 4'd2, 32'h0,   1, 0, 4'd9, 32'h0,   1, 0));
    tbl.push_back(mk(1, 0, 4'd4, 32'h0,   1, 0, 4'd9, 32'h0,   0, 1));
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   0, 0, 4'd0, 32'h0,   0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 32'h0,   0, 0, 4'd0, 32'h0,   0, 0));

    do_reset(3);
    idle(20);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
           tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1,
           1, tbl[i].g0, tbl[i].g1, g0, g1);

    // Random traffic. Each requester keeps its request until it is granted.
    p0v = 0; p1v = 0; p0we = 0; p1we = 0; p0a = 0; p1a = 0; p0d = 0; p1d = 0;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 300; i++) begin
      if (!p0v || g0) begin
        p0v  = ($urandom_range(0, 3) != 0);
        p0we = 1'($urandom_range(0, 1));
        p0a  = 4'($urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, 15));
        p0d  = $urandom;
      end
      if (!p1v || g1) begin
        p1v  = ($urandom_range(0, 3) != 0);
        p1we = 1'($urandom_range(0, 1));
        p1a  = 4'($urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, 15));
        p1d  = $urandom;
      end
      step(p0v, p0we, p0a, p0d, p1v, p1we, p1a, p1d, 0, 0, 0, g0, g1);
    end
    idle(3);

    // Reset with two writes in flight. The second write must never reach the
    // register file. Afterwards the pointer is back at 1, so r0 wins.
    step(1, 1, 4'd8, 32'hAAAA5555, 0, 0, 4'd0, 32'h0, 1, 1, 0, g0, g1);
    step(0, 0, 4'd0, 32'h0, 1, 1, 4'd9, 32'h5A5A5A5A, 1, 0, 1, g0, g1);
    do_reset(2);
    idle(3);
    step(1, 0, 4'd8, 32'h0, 1, 0, 4'd9, 32'h0, 1, 1, 0, g0, g1);
    step(0, 0, 4'd0, 32'h0, 1, 0, 4'd9, 32'h0, 1, 0, 1, g0, g1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
